pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the hold and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers.
- Resolves three hazards:
  - load-use hazards, with a one-bubble stall;
  - multi-cycle multiply/divide occupancy of EX, using an FSM and a down-counter;
  - taken-branch squash, with branches resolved in EX.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline. It handles load-use bubbles,
// multi-cycle mult/div holds of EX, and taken-branch squashes. It also keeps
// a saturating count of cycles in which the PC was held.
module pipe_hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 6,
  parameter int PERF_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        ID_rs,
  input  logic [4:0]        ID_rt,
  input  logic              ID_uses_rt,
  input  logic              EX_mem_read,
  input  logic [4:0]        EX_rt,
  input  logic              EX_md_start,
  input  logic              branch_taken,
  output logic              pc_write,
  output logic              IF_ID_write,
  output logic              IF_ID_flush,
  output logic              ID_EX_write,
  output logic              ID_EX_flush,
  output logic              EX_MEM_flush,
  output logic              md_busy,
  output logic              md_done,
  output logic [PERF_W-1:0] stall_count
);

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MD_WAIT = 1'b1;
  // The start cycle is already one hold cycle, so MD_WAIT covers the remaining MD_LATENCY-1.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 2);

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              md_done_q, md_done_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  logic md_start;
  logic md_hold;
  logic load_use;

  assign md_start = (state_q == ST_RUN) && EX_md_start;
  assign md_hold  = md_start || (state_q == ST_MD_WAIT);
  assign load_use = EX_mem_read && (EX_rt != 5'd0) &&
                    ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));

  // Reset gates every control output directly, so the defaults take effect without a clock edge.
  always_comb begin
    pc_write     = 1'b1;
    IF_ID_write  = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_write  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_flush = 1'b0;
    if (reset) begin
      if (md_hold) begin
        pc_write     = 1'b0;
        IF_ID_write  = 1'b1;
        ID_EX_write  = 1'b1;
        EX_MEM_flush = 1'b1;
      end else if (branch_taken) begin
        IF_ID_flush  = 1'b1;
        ID_EX_flush  = 1'b1;
      end else if (load_use) begin
        pc_write     = 1'b0;
        IF_ID_write  = 1'b1;
        ID_EX_flush  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_done_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (EX_md_start) begin
          cnt_d   = CNT_LOAD;
          state_d = ST_MD_WAIT;
        end
      end
      ST_MD_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d   = ST_RUN;
          md_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      md_done_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      md_done_q   <= md_done_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign md_busy     = (state_q == ST_MD_WAIT);
  assign md_done     = md_done_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. A second instance with PERF_W=4 shares
// the same inputs and exercises stall-counter saturation.
module tb_pipe_hazard_ctrl;

  logic        clock;
  logic        reset;
  logic [4:0]  ID_rs, ID_rt, EX_rt;
  logic        ID_uses_rt, EX_mem_read, EX_md_start, branch_taken;

  logic        pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_flush;
  logic        md_busy, md_done;
  logic [15:0] stall_count;

  logic        pc_write4, IF_ID_write4, IF_ID_flush4, ID_EX_write4, ID_EX_flush4, EX_MEM_flush4;
  logic        md_busy4, md_done4;
  logic [3:0]  stall_count4;

  logic [5:0]  ctrl, ctrl4;
  assign ctrl  = {pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_flush};
  assign ctrl4 = {pc_write4, IF_ID_write4, IF_ID_flush4, ID_EX_write4, ID_EX_flush4, EX_MEM_flush4};

  // {pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_flush}
  localparam logic [5:0] C_DEF  = 6'b100000;
  localparam logic [5:0] C_LU   = 6'b010010;
  localparam logic [5:0] C_BR   = 6'b101010;
  localparam logic [5:0] C_HOLD = 6'b010101;

  int errors = 0;
  int checks = 0;

  pipe_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(6), .PERF_W(16)) u_dut (
    .clock(clock), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
    .EX_mem_read(EX_mem_read), .EX_rt(EX_rt), .EX_md_start(EX_md_start),
    .branch_taken(branch_taken), .pc_write(pc_write), .IF_ID_write(IF_ID_write),
    .IF_ID_flush(IF_ID_flush), .ID_EX_write(ID_EX_write), .ID_EX_flush(ID_EX_flush),
    .EX_MEM_flush(EX_MEM_flush), .md_busy(md_busy), .md_done(md_done),
    .stall_count(stall_count)
  );

  pipe_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(6), .PERF_W(4)) u_dut4 (
    .clock(clock), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
    .EX_mem_read(EX_mem_read), .EX_rt(EX_rt), .EX_md_start(EX_md_start),
    .branch_taken(branch_taken), .pc_write(pc_write4), .IF_ID_write(IF_ID_write4),
    .IF_ID_flush(IF_ID_flush4), .ID_EX_write(ID_EX_write4), .ID_EX_flush(ID_EX_flush4),
    .EX_MEM_flush(EX_MEM_flush4), .md_busy(md_busy4), .md_done(md_done4),
    .stall_count(stall_count4)
  );

  // Clock/reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver tasks: inputs change 1 time unit after a posedge, outputs are sampled at negedge.
  task automatic clear_inputs();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_uses_rt = 1'b0; EX_mem_read = 1'b0;
    EX_rt = 5'd0; EX_md_start = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rs, input logic [4:0] rt,
                              input logic uses_rt, input logic [4:0] ex_rt);
    ID_rs = rs; ID_rt = rt; ID_uses_rt = uses_rt; EX_mem_read = 1'b1; EX_rt = ex_rt;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_load_use(5'd7, 5'd0, 1'b0, 5'd7);
    EX_md_start = 1'b1;
    branch_taken = 1'b1;
    next_cycle();
    @(negedge clock);
    checks++;
    if (ctrl !== C_DEF) begin
      errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, C_DEF);
    end
    checks++;
    if ({md_busy, md_done, md_busy4, md_done4} !== 4'b0000) begin
      errors++; $display("FAIL reset_md: busy=%b done=%b expected 0 0", md_busy, md_done);
    end
    checks++;
    if (stall_count !== 16'd0 || stall_count4 !== 4'd0) begin
      errors++; $display("FAIL reset_count: got %0d/%0d expected 0/0", stall_count, stall_count4);
    end
    next_cycle();
    clear_inputs();
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use(5'd8, 5'd0, 1'b0, 5'd8);
    @(negedge clock);
    checks++;
    if (ctrl !== C_LU) begin
      errors++; $display("FAIL load_use_rs: got %b expected %b", ctrl, C_LU);
    end
    next_cycle();
    clear_inputs();
    @(negedge clock);
    checks++;
    if (ctrl !== C_DEF) begin
      errors++; $display("FAIL load_use_after: got %b expected %b", ctrl, C_DEF);
    end
    checks++;
    if (stall_count !== 16'd1) begin
      errors++; $display("FAIL load_use_count: got %0d expected 1", stall_count);
    end
    next_cycle();
    set_load_use(5'd3, 5'd12, 1'b1, 5'd12);
    @(negedge clock);
    checks++;
    if (ctrl !== C_LU) begin
      errors++; $display("FAIL load_use_rt: got %b expected %b", ctrl, C_LU);
    end
    next_cycle();
    clear_inputs();
    @(negedge clock);
    checks++;
    if (stall_count !== 16'd2) begin
      errors++; $display("FAIL load_use_rt_count: got %0d expected 2", stall_count);
    end
    next_cycle();
  endtask

  task automatic test_reg0_unused();
    do_reset();
    set_load_use(5'd0, 5'd0, 1'b1, 5'd0);
    @(negedge clock);
    checks++;
    if (ctrl !== C_DEF) begin
      errors++; $display("FAIL reg0_no_stall: got %b expected %b", ctrl, C_DEF);
    end
    next_cycle();
    set_load_use(5'd3, 5'd9, 1'b0, 5'd9);
    @(negedge clock);
    checks++;
    if (ctrl !== C_DEF) begin
      errors++; $display("FAIL unused_rt_no_stall: got %b expected %b", ctrl, C_DEF);
    end
    next_cycle();
    clear_inputs();
    @(negedge clock);
    checks++;
    if (stall_count !== 16'd0) begin
      errors++; $display("FAIL reg0_count: got %0d expected 0", stall_count);
    end
  endtask

  task automatic test_branch_load_use();
    do_reset();
    set_load_use(5'd8, 5'd0, 1'b0, 5'd8);
    branch_taken = 1'b1;
    @(negedge clock);
    checks++;
    if (ctrl !== C_BR) begin
      errors++; $display("FAIL branch_over_lu: got %b expected %b", ctrl, C_BR);
    end
    next_cycle();
    clear_inputs();
    @(negedge clock);
    checks++;
    if (stall_count !== 16'd0) begin
      errors++; $display("FAIL branch_count: got %0d expected 0", stall_count);
    end
  endtask

  task automatic test_muldiv();
    do_reset();
    EX_md_start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      checks++;
      if (ctrl !== C_HOLD) begin
        errors++; $display("FAIL md_hold_c%0d: got %b expected %b", c, ctrl, C_HOLD);
      end
      checks++;
      if (md_busy !== (c >= 2) || md_done !== 1'b0) begin
        errors++; $display("FAIL md_busy_c%0d: busy=%b done=%b expected %b 0", c, md_busy, md_done, (c >= 2));
      end
      next_cycle();
      EX_md_start = 1'b0;
      // Branch and load-use requests inside the hold must be ignored.
      if (c < 3) begin
        branch_taken = 1'b1;
        set_load_use(5'd4, 5'd0, 1'b0, 5'd4);
      end else begin
        clear_inputs();
      end
    end
    @(negedge clock);
    checks++;
    if (ctrl !== C_DEF || md_busy !== 1'b0 || md_done !== 1'b1) begin
      errors++; $display("FAIL md_cycle5: ctrl=%b busy=%b done=%b expected %b 0 1", ctrl, md_busy, md_done, C_DEF);
    end
    checks++;
    if (stall_count !== 16'd4) begin
      errors++; $display("FAIL md_count: got %0d expected 4", stall_count);
    end
    next_cycle();
    @(negedge clock);
    checks++;
    if (md_done !== 1'b0) begin
      errors++; $display("FAIL md_done_pulse: got %b expected 0", md_done);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    EX_md_start = 1'b1;
    next_cycle();
    EX_md_start = 1'b0;
    set_load_use(5'd6, 5'd0, 1'b0, 5'd6);
    #2;
    checks++;
    if (md_busy !== 1'b1) begin
      errors++; $display("FAIL mid_op_busy: got %b expected 1", md_busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_DEF || md_busy !== 1'b0 || md_done !== 1'b0 || stall_count !== 16'd0) begin
      errors++; $display("FAIL mid_op_reset: ctrl=%b busy=%b done=%b cnt=%0d expected %b 0 0 0",
                         ctrl, md_busy, md_done, stall_count, C_DEF);
    end
    next_cycle();
    clear_inputs();
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      checks++;
      if (ctrl !== C_DEF || md_busy !== 1'b0 || md_done !== 1'b0) begin
        errors++; $display("FAIL post_reset_c%0d: ctrl=%b busy=%b done=%b expected %b 0 0", c, ctrl, md_busy, md_done, C_DEF);
      end
      next_cycle();
    end
    // A load-use stall only occurs in RUN, so this confirms the state after reset.
    set_load_use(5'd6, 5'd0, 1'b0, 5'd6);
    @(negedge clock);
    checks++;
    if (ctrl !== C_LU) begin
      errors++; $display("FAIL post_reset_run: got %b expected %b", ctrl, C_LU);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_saturation();
    logic [3:0] exp4;
    do_reset();
    set_load_use(5'd10, 5'd0, 1'b0, 5'd10);
    for (int i = 1; i <= 20; i++) begin
      next_cycle();
      exp4 = (i > 15) ? 4'd15 : 4'(i);
      @(negedge clock);
      checks++;
      if (stall_count4 !== exp4 || ctrl4 !== C_LU) begin
        errors++; $display("FAIL sat_i%0d: cnt=%0d ctrl=%b expected %0d %b", i, stall_count4, ctrl4, exp4, C_LU);
      end
    end
    checks++;
    if (stall_count !== 16'd20) begin
      errors++; $display("FAIL sat_wide_count: got %0d expected 20", stall_count);
    end
    next_cycle();
    clear_inputs();
    next_cycle();
    @(negedge clock);
    checks++;
    if (stall_count4 !== 4'd15) begin
      errors++; $display("FAIL sat_hold: got %0d expected 15", stall_count4);
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    test_reset();
    test_load_use();
    test_reg0_unused();
    test_branch_load_use();
    test_muldiv();
    test_reset_mid_op();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
